// File: rtl/multi_rail_monitor_pkg.sv
// Shared definitions for the multi-rail power supervisor:
// the per-rail state encoding and a small fault-state helper.
package multi_rail_monitor_pkg;

  localparam int STATE_WIDTH = 3;

  typedef enum logic [STATE_WIDTH-1:0] {
    ST_OFF     = 3'd0,
    ST_STARTUP = 3'd1,
    ST_GOOD    = 3'd2,
    ST_VFAULT  = 3'd3,
    ST_IFAULT  = 3'd4
  } rail_state_t;

  // True for either latched fault state
  function automatic logic is_fault(input rail_state_t s);
    return (s == ST_VFAULT) || (s == ST_IFAULT);
  endfunction

endpackage

// File: rtl/multi_rail_monitor_rail_supervisor.sv
// One rail's supervision FSM: stability window before GOOD, fault filter
// window while GOOD, and fault latching until an explicit clear.
// Next-state flags are exported so the top level can build aggregate
// flags that line up with the registered per-rail outputs.
module rail_supervisor
  import multi_rail_monitor_pkg::*;
#(
  parameter int STARTUP_DELAY = 0,
  parameter int ERROR_DELAY   = 0,
  parameter int COUNTER_WIDTH = 23
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic voltage_good,
  input  logic current_good,
  input  logic fault_clear,
  output logic rail_good,
  output logic voltage_fault,
  output logic current_fault,
  output logic good_next,
  output logic fault_next
);

  localparam logic [COUNTER_WIDTH-1:0] START_LIMIT = COUNTER_WIDTH'(STARTUP_DELAY);
  localparam logic [COUNTER_WIDTH-1:0] ERROR_LIMIT = COUNTER_WIDTH'(ERROR_DELAY);

  rail_state_t              state_reg, state_next;
  logic [COUNTER_WIDTH-1:0] count_reg, count_next;
  logic                     sample_ok;

  assign sample_ok = voltage_good & current_good;

  // Next-state and counter logic; the counter restarts on every state change,
  // so the equality compares always fire before it could saturate
  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    unique case (state_reg)
      ST_OFF: begin
        if (enable) state_next = ST_STARTUP;
      end
      ST_STARTUP: begin
        if (!enable) begin
          state_next = ST_OFF;
        end else if (sample_ok) begin
          if (count_reg == START_LIMIT) state_next = ST_GOOD;
          else                          count_next = count_reg + 1'b1;
        end else begin
          count_next = '0;
        end
      end
      ST_GOOD: begin
        if (!enable) begin
          state_next = ST_OFF;
        end else if (!sample_ok) begin
          // Voltage fault takes priority when both comparators are low
          if (count_reg == ERROR_LIMIT) state_next = voltage_good ? ST_IFAULT : ST_VFAULT;
          else                          count_next = count_reg + 1'b1;
        end else begin
          count_next = '0;
        end
      end
      ST_VFAULT, ST_IFAULT: begin
        if (fault_clear) state_next = enable ? ST_STARTUP : ST_OFF;
      end
      default: state_next = ST_OFF;
    endcase
    if (state_next != state_reg) count_next = '0;
  end

  assign good_next  = (state_next == ST_GOOD);
  assign fault_next = is_fault(state_next);

  // State, counter and decoded status LEDs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_OFF;
      count_reg     <= '0;
      rail_good     <= 1'b0;
      voltage_fault <= 1'b0;
      current_fault <= 1'b0;
    end else begin
      state_reg     <= state_next;
      count_reg     <= count_next;
      rail_good     <= (state_next == ST_GOOD);
      voltage_fault <= (state_next == ST_VFAULT);
      current_fault <= (state_next == ST_IFAULT);
    end
  end

endmodule

// File: rtl/multi_rail_monitor.sv
// Multi-rail power supervisor top: one rail_supervisor per rail, plus
// aggregate good/fault flags and the fault-shutdown enable register.
module multi_rail_monitor
  import multi_rail_monitor_pkg::*;
#(
  parameter int NUM_RAILS      = 4,
  parameter int STARTUP_DELAY  = 0,
  parameter int ERROR_DELAY    = 0,
  parameter int COUNTER_WIDTH  = 23,
  parameter int FAULT_SHUTDOWN = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [NUM_RAILS-1:0] i_enable,
  input  logic [NUM_RAILS-1:0] i_voltageGood,
  input  logic [NUM_RAILS-1:0] i_currentGood,
  input  logic                 i_faultClear,
  output logic [NUM_RAILS-1:0] o_railEnable,
  output logic [NUM_RAILS-1:0] o_railGood,
  output logic [NUM_RAILS-1:0] o_voltageFault,
  output logic [NUM_RAILS-1:0] o_currentFault,
  output logic                 o_allGood,
  output logic                 o_anyFault
);

  logic [NUM_RAILS-1:0] good_next;
  logic [NUM_RAILS-1:0] fault_next;
  logic                 any_fault_next;
  logic                 all_good_next;
  logic                 shutdown_next;
  logic [NUM_RAILS-1:0] rail_enable_reg;
  logic                 all_good_reg;
  logic                 any_fault_reg;

  generate
    for (genvar gi = 0; gi < NUM_RAILS; gi++) begin : g_rail
      rail_supervisor #(
        .STARTUP_DELAY (STARTUP_DELAY),
        .ERROR_DELAY   (ERROR_DELAY),
        .COUNTER_WIDTH (COUNTER_WIDTH)
      ) u_rail (
        .clk           (i_clk),
        .rst           (i_rst),
        .enable        (i_enable[gi]),
        .voltage_good  (i_voltageGood[gi]),
        .current_good  (i_currentGood[gi]),
        .fault_clear   (i_faultClear),
        .rail_good     (o_railGood[gi]),
        .voltage_fault (o_voltageFault[gi]),
        .current_fault (o_currentFault[gi]),
        .good_next     (good_next[gi]),
        .fault_next    (fault_next[gi])
      );
    end
  endgenerate

  // Aggregates from next-state so they align with the per-rail outputs
  always_comb begin
    any_fault_next = |fault_next;
    all_good_next  = (|i_enable) && (&(good_next | ~i_enable));
    shutdown_next  = (FAULT_SHUTDOWN != 0) && any_fault_next;
  end

  // Registered rail enables and aggregate flags
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rail_enable_reg <= '0;
      all_good_reg    <= 1'b0;
      any_fault_reg   <= 1'b0;
    end else begin
      rail_enable_reg <= i_enable & ~{NUM_RAILS{shutdown_next}};
      all_good_reg    <= all_good_next;
      any_fault_reg   <= any_fault_next;
    end
  end

  assign o_railEnable = rail_enable_reg;
  assign o_allGood    = all_good_reg;
  assign o_anyFault   = any_fault_reg;

endmodule

// File: tb/tb_multi_rail_monitor.sv
// Directed and randomized check of multi_rail_monitor against a
// streak-counting reference model of the rail supervision rules.
module tb_multi_rail_monitor;

  localparam int N  = 2;
  localparam int SD = 3;
  localparam int ED = 2;

  // Model rail modes
  localparam int M_OFF = 0, M_START = 1, M_GOOD = 2, M_VF = 3, M_IF = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] en  = '0;
  logic [N-1:0] vg  = '1;
  logic [N-1:0] cg  = '1;
  logic         clr = 1'b0;
  logic [N-1:0] rail_enable, rail_good, voltage_fault, current_fault;
  logic         all_good, any_fault;

  int checks_total  = 0;
  int checks_passed = 0;

  int           m_mode   [N];
  int           m_streak [N];
  logic [N-1:0] m_enable_out;
  logic         m_all_good, m_any_fault;

  multi_rail_monitor #(
    .NUM_RAILS      (N),
    .STARTUP_DELAY  (SD),
    .ERROR_DELAY    (ED),
    .COUNTER_WIDTH  (8),
    .FAULT_SHUTDOWN (1)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_enable       (en),
    .i_voltageGood  (vg),
    .i_currentGood  (cg),
    .i_faultClear   (clr),
    .o_railEnable   (rail_enable),
    .o_railGood     (rail_good),
    .o_voltageFault (voltage_fault),
    .o_currentFault (current_fault),
    .o_allGood      (all_good),
    .o_anyFault     (any_fault)
  );

  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks_total++;
    if (observed === expected) checks_passed++;
    else $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, observed, expected, $time);
  endtask

  function automatic logic [N-1:0] mode_mask(input int mode);
    logic [N-1:0] m;
    for (int r = 0; r < N; r++) m[r] = (m_mode[r] == mode);
    return m;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < N; r++) begin
      m_mode[r]   = M_OFF;
      m_streak[r] = 0;
    end
    m_enable_out = '0;
    m_all_good   = 1'b0;
    m_any_fault  = 1'b0;
  endtask

  // One clock edge worth of the supervision rules, using run lengths of
  // consecutive good / bad samples
  task automatic model_edge();
    logic all_ok;
    if (rst) begin
      model_reset();
      return;
    end
    for (int r = 0; r < N; r++) begin
      logic ok;
      ok = vg[r] && cg[r];
      if (m_mode[r] == M_OFF) begin
        if (en[r]) begin m_mode[r] = M_START; m_streak[r] = 0; end
      end else if (m_mode[r] == M_START) begin
        if (!en[r]) begin m_mode[r] = M_OFF; m_streak[r] = 0; end
        else if (ok) begin
          m_streak[r]++;
          if (m_streak[r] == SD + 1) begin m_mode[r] = M_GOOD; m_streak[r] = 0; end
        end else m_streak[r] = 0;
      end else if (m_mode[r] == M_GOOD) begin
        if (!en[r]) begin m_mode[r] = M_OFF; m_streak[r] = 0; end
        else if (!ok) begin
          m_streak[r]++;
          if (m_streak[r] == ED + 1) begin
            m_mode[r] = vg[r] ? M_IF : M_VF;
            m_streak[r] = 0;
          end
        end else m_streak[r] = 0;
      end else begin
        if (clr) begin m_mode[r] = en[r] ? M_START : M_OFF; m_streak[r] = 0; end
      end
    end
    m_any_fault  = |(mode_mask(M_VF) | mode_mask(M_IF));
    m_enable_out = m_any_fault ? '0 : en;
    all_ok = 1'b1;
    for (int r = 0; r < N; r++) if (en[r] && m_mode[r] != M_GOOD) all_ok = 1'b0;
    m_all_good = (en != '0) && all_ok;
  endtask

  task automatic compare_all();
    check_value("rail_enable", 32'(rail_enable), 32'(m_enable_out));
    check_value("rail_good", 32'(rail_good), 32'(mode_mask(M_GOOD)));
    check_value("voltage_fault", 32'(voltage_fault), 32'(mode_mask(M_VF)));
    check_value("current_fault", 32'(current_fault), 32'(mode_mask(M_IF)));
    check_value("all_good", 32'(all_good), 32'(m_all_good));
    check_value("any_fault", 32'(any_fault), 32'(m_any_fault));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  // Assert reset between edges and confirm outputs drop without a clock
  task automatic async_reset_check(input string tag);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_value(tag, 32'({rail_enable, rail_good, voltage_fault, current_fault, all_good, any_fault}), 32'd0);
    compare_all();
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    int n;
    model_reset();
    #1;
    compare_all();
    step();
    rst = 1'b0;

    // Rail 0 start-up latency
    en = 2'b01;
    n = 0;
    do begin step(); n++; end while (!rail_good[0] && n < 20);
    check_value("startup_latency", 32'(n), 32'd5);
    check_value("rail1_idle", 32'(rail_good[1]), 32'd0);

    // Glitch during STARTUP restarts the window
    en = 2'b00; step();
    en = 2'b01; step();
    step(); step();
    vg[0] = 1'b0; step();
    vg[0] = 1'b1;
    n = 0;
    do begin step(); n++; end while (!rail_good[0] && n < 20);
    check_value("restart_latency", 32'(n), 32'd4);

    // Bring rail 1 up, then short current dip vs. a real current fault
    en = 2'b11;
    repeat (5) step();
    check_value("both_good", 32'(rail_good), 32'd3);
    cg[0] = 1'b0; step(); step();
    cg[0] = 1'b1; step();
    check_value("short_dip", 32'(current_fault), 32'd0);
    cg[0] = 1'b0; step(); step(); step();
    check_value("ifault_latch", 32'(current_fault[0]), 32'd1);
    check_value("ifault_good_drop", 32'(rail_good[0]), 32'd0);
    check_value("shutdown", 32'(rail_enable), 32'd0);

    // Clear, restart, then voltage fault with both comparators low
    cg[0] = 1'b1; clr = 1'b1; step(); clr = 1'b0;
    repeat (4) step();
    check_value("regood", 32'(rail_good), 32'd3);
    vg[0] = 1'b0; cg[0] = 1'b0;
    repeat (3) step();
    check_value("vfault_pri", 32'({voltage_fault[0], current_fault[0]}), 32'd2);
    en = 2'b00; step(); step();
    check_value("fault_persists", 32'(voltage_fault[0]), 32'd1);
    clr = 1'b1; step(); clr = 1'b0;
    check_value("clear_to_off", 32'(any_fault), 32'd0);
    step();
    vg = '1; cg = '1;

    // Clear pulse on the same edge another rail latches
    en = 2'b11;
    repeat (5) step();
    cg[0] = 1'b0; repeat (3) step(); cg[0] = 1'b1;
    cg[1] = 1'b0; step(); step();
    clr = 1'b1; step(); clr = 1'b0;
    check_value("clear_vs_latch", 32'(current_fault), 32'd2);
    cg[1] = 1'b1;

    // Asynchronous reset mid-fault and mid-startup
    async_reset_check("reset_mid_fault");
    en = 2'b01; step(); step();
    async_reset_check("reset_mid_startup");

    // Randomized traffic
    en = 2'b00;
    for (int i = 0; i < 3000; i++) begin
      for (int r = 0; r < N; r++) begin
        if ($urandom_range(39) == 0) en[r] = ~en[r];
        vg[r] = ($urandom_range(5) != 0);
        cg[r] = ($urandom_range(5) != 0);
      end
      clr = ($urandom_range(29) == 0);
      step();
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
